jtag_tap_sync: RTL and testbench

Synthesizable IEEE 1149.1 TAP controller on the device side of the JTAG pads: it consumes TCK/TMS/TDI/TRST_N from the debugger and produces TDO. TCK is not used as a clock. All pad inputs are oversampled and synchronized into the single system clock, and TCK edges are detected as one-cycle strobes. The block implements the 16-state TAP FSM, an instruction register, BYPASS, IDCODE and one USER data register that is exposed to core logic.

---
 rtl/jtag_tap_sync_if.sv | 25 ++
 rtl/jtag_tap_sync.sv | 119 +++++++++++
 tb/tb_jtag_tap_sync.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_sync_if.sv
// jtag_tap_sync_if: JTAG pad and core-side signals of the TAP controller
interface jtag_tap_sync_if #(
  parameter int IR_LEN   = 4,
  parameter int USER_LEN = 32
);
  logic                tck;
  logic                tms;
  logic                tdi;
  logic                trst_n;
  logic                tdo;
  logic                tdo_en;
  logic [3:0]          tap_state;
  logic [IR_LEN-1:0]   ir_value;
  logic [USER_LEN-1:0] user_capture_data;
  logic [USER_LEN-1:0] user_dr;
  logic                user_update;
  modport master (
    output tck, tms, tdi, trst_n, user_capture_data,
    input  tdo, tdo_en, tap_state, ir_value, user_dr, user_update
  );
  modport slave (
    input  tck, tms, tdi, trst_n, user_capture_data,
    output tdo, tdo_en, tap_state, ir_value, user_dr, user_update
  );
endinterface

// File: rtl/jtag_tap_sync.sv
// jtag_tap_sync: oversampled IEEE 1149.1 TAP with IR, BYPASS, IDCODE and USER data register
module jtag_tap_sync #(
  parameter int          IR_LEN      = 4,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001,
  parameter int          USER_LEN    = 32,
  parameter int          SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  jtag_tap_sync_if.slave  jtag
);
  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } state_t;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_USER   = IR_IDCODE << (IR_LEN - 1);
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic                        tck_s, tms_s, tdi_s, trst_s, tck_q;
  logic                        tck_rise, tck_fall;
  state_t                      state, nxt;
  logic [IR_LEN-1:0]           ir, ir_sr;
  logic [31:0]                 id_sr;
  logic [USER_LEN-1:0]         user_sr, user_dr;
  logic                        byp_sr, tdo, tdo_en, user_update;
  logic                        sel_idcode, sel_user, dr_lsb;
  assign {tck_s, tms_s, tdi_s, trst_s} = sync[SYNC_STAGES-1];
  assign tck_rise   = tck_s & ~tck_q;
  assign tck_fall   = ~tck_s & tck_q;
  assign sel_idcode = ir == IR_IDCODE;
  assign sel_user   = ir == IR_USER;
  assign dr_lsb     = sel_user ? user_sr[0] : sel_idcode ? id_sr[0] : byp_sr;
  assign jtag.tdo         = tdo;
  assign jtag.tdo_en      = tdo_en;
  assign jtag.tap_state   = state;
  assign jtag.ir_value    = ir;
  assign jtag.user_dr     = user_dr;
  assign jtag.user_update = user_update;
  // Pads idle high through external pull-ups, so the synchronizer resets to 1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '1;
      tck_q <= 1'b1;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], {jtag.tck, jtag.tms, jtag.tdi, jtag.trst_n}};
      tck_q <= tck_s;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      TLR:      nxt = tms_s ? TLR    : RTI;
      RTI:      nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:   nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms_s ? EX1_DR : SHIFT_DR;
      SHIFT_DR: nxt = tms_s ? EX1_DR : SHIFT_DR;
      EX1_DR:   nxt = tms_s ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms_s ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms_s ? UPD_DR : SHIFT_DR;
      UPD_DR:   nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:   nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms_s ? EX1_IR : SHIFT_IR;
      SHIFT_IR: nxt = tms_s ? EX1_IR : SHIFT_IR;
      EX1_IR:   nxt = tms_s ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms_s ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms_s ? UPD_IR : SHIFT_IR;
      UPD_IR:   nxt = tms_s ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TLR;
      ir          <= IR_IDCODE;
      ir_sr       <= '0;
      id_sr       <= '0;
      user_sr     <= '0;
      byp_sr      <= 1'b0;
      tdo         <= 1'b0;
      tdo_en      <= 1'b0;
      user_dr     <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (!trst_s) begin
        state  <= TLR;
        ir     <= IR_IDCODE;
        tdo_en <= 1'b0;
      end else if (tck_rise) begin
        state  <= nxt;
        tdo_en <= (nxt == SHIFT_IR) || (nxt == SHIFT_DR);
        if (nxt == TLR) ir <= IR_IDCODE;
        if (state == CAP_IR) ir_sr <= IR_IDCODE;
        if (state == SHIFT_IR) ir_sr <= IR_LEN'({tdi_s, ir_sr} >> 1);
        if (state == CAP_DR) begin
          id_sr   <= IDCODE_VAL;
          byp_sr  <= 1'b0;
          user_sr <= jtag.user_capture_data;
        end
        // Shift-DR moves only the register selected by the active instruction
        if (state == SHIFT_DR) begin
          if (sel_user) user_sr <= USER_LEN'({tdi_s, user_sr} >> 1);
          else if (sel_idcode) id_sr <= {tdi_s, id_sr[31:1]};
          else byp_sr <= tdi_s;
        end
      end else if (tck_fall) begin
        if (state == SHIFT_IR) tdo <= ir_sr[0];
        else if (state == SHIFT_DR) tdo <= dr_lsb;
        if (state == UPD_IR) ir <= ir_sr;
        if (state == UPD_DR && sel_user) begin
          user_dr     <= user_sr;
          user_update <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_tap_sync.sv
// tb_jtag_tap_sync: directed scans and TAP graph walk against a hand-written state model
module tb_jtag_tap_sync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  jtag_tap_sync_if #(.IR_LEN(4), .USER_LEN(32)) bus();
  jtag_tap_sync #(.IR_LEN(4), .IDCODE_VAL(32'h1000_0001), .USER_LEN(32), .SYNC_STAGES(2))
    dut (.clk(clk), .rst(rst), .jtag(bus));
  int          tests = 0;
  int          fails = 0;
  int          upd_cnt = 0;
  int          c0;
  logic [31:0] upd_val = '0;
  logic [3:0]  ms = 4'hF;
  logic [63:0] d;
  logic        junk;
  logic [3:0]  tgt   [16] = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                              4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
  int          plen  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  logic [7:0]  pbits [16] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                              8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
  logic [63:0] pat = 64'h9C3A_5E61_D2B7_0F48;
  always @(negedge clk)
    if (bus.user_update) begin
      upd_cnt <= upd_cnt + 1;
      upd_val <= bus.user_dr;
    end
  function automatic logic [3:0] ref_next(input logic [3:0] s, input logic t);
    case (s)
      4'hF: return t ? 4'hF : 4'hC;
      4'hC: return t ? 4'h7 : 4'hC;
      4'h7: return t ? 4'h4 : 4'h6;
      4'h6: return t ? 4'h1 : 4'h2;
      4'h2: return t ? 4'h1 : 4'h2;
      4'h1: return t ? 4'h5 : 4'h3;
      4'h3: return t ? 4'h0 : 4'h3;
      4'h0: return t ? 4'h5 : 4'h2;
      4'h5: return t ? 4'h7 : 4'hC;
      4'h4: return t ? 4'hF : 4'hE;
      4'hE: return t ? 4'h9 : 4'hA;
      4'hA: return t ? 4'h9 : 4'hA;
      4'h9: return t ? 4'hD : 4'hB;
      4'hB: return t ? 4'h8 : 4'hB;
      4'h8: return t ? 4'hD : 4'hA;
      default: return t ? 4'h7 : 4'hC;
    endcase
  endfunction
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // One TCK period; TDO is returned as seen after this period's falling edge
  task automatic tick(input logic m, input logic di, output logic o);
    @(negedge clk);
    bus.tms = m;
    bus.tdi = di;
    clks(3);
    bus.tck = 1'b1;
    clks(2);
    chk("state_latency", {60'd0, bus.tap_state}, {60'd0, ms});
    clks(1);
    ms = ref_next(ms, m);
    chk("state", {60'd0, bus.tap_state}, {60'd0, ms});
    chk("tdo_en", {63'd0, bus.tdo_en}, {63'd0, (ms == 4'h2) || (ms == 4'hA)});
    clks(5);
    bus.tck = 1'b0;
    clks(6);
    o = bus.tdo;
  endtask
  task automatic goto_rti();
    repeat (5) tick(1'b1, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
  endtask
  task automatic scan(input bit ir, input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    tick(1'b1, 1'b1, o);
    if (ir) tick(1'b1, 1'b1, o);
    tick(1'b0, 1'b1, o);
    tick(1'b0, 1'b1, o);
    dout[0] = o;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], o);
      if (i < n - 1) dout[i+1] = o;
    end
    tick(1'b1, 1'b1, o);
    tick(1'b0, 1'b1, o);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, {60'd0, bus.tap_state}, 64'hF);
    chk({tag, "_ir"}, {60'd0, bus.ir_value}, 64'h1);
    chk({tag, "_tdo"}, {63'd0, bus.tdo}, 64'h0);
    chk({tag, "_tdo_en"}, {63'd0, bus.tdo_en}, 64'h0);
    chk({tag, "_user_dr"}, {32'd0, bus.user_dr}, 64'h0);
    chk({tag, "_user_update"}, {63'd0, bus.user_update}, 64'h0);
  endtask
  initial begin
    bus.tck = 1'b0;
    bus.tms = 1'b1;
    bus.tdi = 1'b1;
    bus.trst_n = 1'b1;
    bus.user_capture_data = 32'hDEAD_BEEF;
    clks(3);
    chk_reset_outputs("reset");
    rst = 1'b0;
    clks(4);
    goto_rti();
    c0 = upd_cnt;
    scan(1'b0, 32, 64'h0, d);
    chk("idcode", d, 64'h1000_0001);
    chk("idcode_no_update", upd_cnt - c0, 0);
    scan(1'b1, 4, 64'hF, d);
    chk("ir_capture_bypass", d, 64'h1);
    chk("ir_bypass", {60'd0, bus.ir_value}, 64'hF);
    scan(1'b0, 8, 64'hA5, d);
    chk("bypass_delay", d, 64'h4A);
    scan(1'b1, 4, 64'h8, d);
    chk("ir_capture_user", d, 64'h1);
    chk("ir_user", {60'd0, bus.ir_value}, 64'h8);
    c0 = upd_cnt;
    scan(1'b0, 32, 64'h1234_5678, d);
    chk("user_capture", d, 64'hDEAD_BEEF);
    chk("user_dr", {32'd0, bus.user_dr}, 64'h1234_5678);
    chk("user_update_pulses", upd_cnt - c0, 1);
    chk("user_dr_at_pulse", {32'd0, upd_val}, 64'h1234_5678);
    tick(1'b1, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
    bus.trst_n = 1'b0;
    ms = 4'hF;
    repeat (4) tick(1'b1, 1'b1, junk);
    chk("trst_state", {60'd0, bus.tap_state}, 64'hF);
    chk("trst_ir", {60'd0, bus.ir_value}, 64'h1);
    chk("trst_user_dr", {32'd0, bus.user_dr}, 64'h1234_5678);
    chk("trst_tdo_en", {63'd0, bus.tdo_en}, 64'h0);
    bus.trst_n = 1'b1;
    clks(4);
    goto_rti();
    tick(1'b1, 1'b1, junk);
    tick(1'b1, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
    tick(1'b0, 1'b1, junk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_mid_ir");
    rst = 1'b0;
    ms = 4'hF;
    clks(4);
    goto_rti();
    scan(1'b0, 32, 64'h0, d);
    chk("idcode_after_rst", d, 64'h1000_0001);
    for (int t = 0; t < 16; t++) begin
      repeat (5) tick(1'b1, 1'b1, junk);
      for (int i = 0; i < plen[t]; i++) tick(pbits[t][i], 1'b0, junk);
      chk("walk_target", {60'd0, bus.tap_state}, {60'd0, tgt[t]});
      repeat (5) tick(1'b1, 1'b1, junk);
      chk("five_tms_to_tlr", {60'd0, bus.tap_state}, 64'hF);
    end
    for (int i = 0; i < 64; i++) tick(pat[i], pat[63-i], junk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
